jam_cost_arbiter: RTL and testbench
===================================

# jam_cost_arbiter

Round-robin scheduler sharing the single combinational Cost ROM port (W/J in, 7-bit Cost out) among several permutation-search engines. Each engine holds the ROM for a burst of up to one full assignment (8 worker reads), then the port rotates to the next requester. The block sits between the engines and the testbench-side Cost ROM, registering the ROM address and the returned cost so ROM timing is isolated from engine logic.

## Interface
- N_REQ, 4, number of requesting engines (2..8)
- BURST_LEN, 8, max accepted accesses per grant (1..15)
- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- req  input  N_REQ  per-engine ROM request, level
- req_w  input  3*N_REQ  worker index, engine i at bits [3i+2:3i]
- req_j  input  3*N_REQ  job index, same packing
- gnt  output  N_REQ  registered one-hot grant (all zero when idle)
- W  output  3  registered ROM worker address
- J  output  3  registered ROM job address
- Cost  input  7  ROM data, combinational from W/J
- rdata  output  7  registered cost returned to owner
- rvalid  output  N_REQ  one-hot, 1-cycle pulse marking rdata for engine i
- busy  output  1  high while state is GRANT

## Operation
- FSM: IDLE, GRANT.
- IDLE: gnt=0. If any req bit high at edge, pick winner = first set bit scanning from rr_ptr upward with wrap; owner<=winner, gnt<=onehot(winner), burst_cnt<=0, go GRANT. No req: stay IDLE.
- GRANT: access accepted at edge where gnt[owner]&req[owner]. On accept: W<=req_w[owner], J<=req_j[owner], burst_cnt+1, pending<=1, pend_id<=owner.
- Burst ends at edge where (accept and burst_cnt+1==BURST_LEN) or req[owner]==0. Then gnt<=0, rr_ptr<=owner+1 (mod N_REQ), go IDLE. Dropped req is not an access.
- Return path: each edge, if pending then rdata<=Cost, rvalid<=onehot(pend_id); else rvalid<=0, rdata holds. pending clears unless new accept.
- Non-owner req bits ignored during GRANT; request lines of losers must stay asserted to be served later.
- Guaranteed single IDLE cycle between bursts, including re-grant of same engine.
- burst_cnt 4 bits; W/J hold last value when no access.
- Reset values: gnt=0, W=0, J=0, rdata=0, rvalid=0, busy=0, rr_ptr=0, state IDLE, pending=0.

## Timing
- req high at edge e (IDLE) -> gnt high after e.
- Accept at edge a -> W/J valid after a -> rdata/rvalid valid after a+1 (2-edge latency from accept, 1 from address).
- Full burst of 8: 1 arbitration cycle + 8 accept cycles + 1 IDLE; last rvalid pulses during the IDLE cycle, overlapping nothing from the next owner (its first rvalid ≥2 cycles later).
- Back-to-back accepts give back-to-back rvalid pulses, in order.
- Simultaneous: req drop by owner and new req from others same edge -> release this edge, arbitrate next IDLE edge.
- RST mid-burst: all state and outputs to reset values immediately; in-flight cost discarded, no rvalid.

## Configuration
- JAM_ARB_FIXED_PRIO_EN defined: IDLE winner is lowest-index set req bit; rr_ptr frozen at 0. Undefined: round-robin as above. Burst and return timing identical in both.

## Test plan
- Single engine: req[0]=1 for 8 accesses, addresses (w,j)=(0..7,3), ROM Cost=w*10+j -> gnt[0] one cycle after req, rdata sequence 3,13,…,73 with rvalid[0] each cycle, gnt drops after 8th accept, busy low one cycle.
- Round robin: req=4'b1111 held -> grant order 0,1,2,3,0, each exactly 8 accepts, one idle cycle between.
- Early release: engine 2 drops req after 3 accepts -> exactly 3 rvalid[2] pulses, rr_ptr=3, next winner engine 3 (with req=4'b1001).
- Wrap: owner 3 finishes, only req[0] and req[3] high -> engine 0 wins.
- Reset mid-burst after 4 accepts -> gnt=0, rvalid=0, W=J=0 immediately; after release with req[1] only -> engine 1 granted, rr restarts from 0.
- JAM_ARB_FIXED_PRIO_EN: req=4'b1010 held -> engine 1 granted every burst, engine 3 never.

Source files
------------

// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter: round-robin owner of the shared Cost ROM port, burst per grant.
// Define JAM_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module jam_cost_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_w,
  input  logic [3*N_REQ-1:0] req_j,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         W,
  output logic [2:0]         J,
  input  logic [6:0]         Cost,
  output logic [6:0]         rdata,
  output logic [N_REQ-1:0]   rvalid,
  output logic               busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]    owner, owner_n;
  logic [IW-1:0]    rr_ptr, rr_ptr_n;
  logic [IW-1:0]    pend_id, pend_id_n;
  logic [3:0]       burst_cnt, burst_cnt_n;
  logic             pending, pending_n;
  logic [N_REQ-1:0] gnt_n, rvalid_n;
  logic [2:0]       w_n, j_n;
  logic [6:0]       rdata_n;

  logic [IW-1:0] base, idx, winner;
  logic          found;
  logic          accept, last;

  function automatic logic [IW-1:0] wrap_inc(
    input logic [IW-1:0] b,
    input int            k
  );
    int t;
    t = int'(b) + k;
    if (t >= N_REQ) t = t - N_REQ;
    return IW'(t);
  endfunction

`ifdef JAM_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  assign base = rr_ptr;
`endif

  // first requester at or after base, wrapping
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = wrap_inc(base, k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign accept = (state == GRANT) && gnt[owner] && req[owner];
  assign last   = (accept && (burst_cnt + 4'd1 == 4'(BURST_LEN)))
                || ((state == GRANT) && !req[owner]);
  assign busy   = (state == GRANT);

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    gnt_n       = gnt;
    w_n         = W;
    j_n         = J;
    pending_n   = accept;
    pend_id_n   = pend_id;
    rdata_n     = rdata;
    rvalid_n    = '0;

    if (pending) begin
      rdata_n           = Cost;
      rvalid_n[pend_id] = 1'b1;
    end

    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          owner_n        = winner;
          gnt_n[winner]  = 1'b1;
          burst_cnt_n    = '0;
          state_n        = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          w_n         = req_w[int'(owner)*3 +: 3];
          j_n         = req_j[int'(owner)*3 +: 3];
          burst_cnt_n = burst_cnt + 4'd1;
          pend_id_n   = owner;
        end
        if (last) begin
          gnt_n   = '0;
          state_n = IDLE;
`ifdef JAM_ARB_FIXED_PRIO_EN
          rr_ptr_n = '0;
`else
          rr_ptr_n = wrap_inc(owner, 1);
`endif
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      pend_id   <= '0;
      burst_cnt <= '0;
      pending   <= 1'b0;
      gnt       <= '0;
      W         <= '0;
      J         <= '0;
      rdata     <= '0;
      rvalid    <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      pend_id   <= pend_id_n;
      burst_cnt <= burst_cnt_n;
      pending   <= pending_n;
      gnt       <= gnt_n;
      W         <= w_n;
      J         <= j_n;
      rdata     <= rdata_n;
      rvalid    <= rvalid_n;
    end
  end

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// tb_jam_cost_arbiter: cycle table for one engine, scoreboarded multi-engine runs.
// Expected grant orders switch with JAM_ARB_FIXED_PRIO_EN.
module tb_jam_cost_arbiter;

  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req, gnt, rvalid;
  logic [3*N-1:0] req_w, req_j;
  logic [2:0]     W, J;
  logic [6:0]     Cost, rdata;
  logic           busy;

  jam_cost_arbiter #(.N_REQ(N), .BURST_LEN(8)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_w(req_w), .req_j(req_j),
    .gnt(gnt), .W(W), .J(J), .Cost(Cost), .rdata(rdata),
    .rvalid(rvalid), .busy(busy)
  );

  // ROM: cost = w*10 + j
  assign Cost = {4'b0, W} * 7'd10 + {4'b0, J};

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] rq;
    logic [2:0] w;
    logic [3:0] g;
    logic       b;
    logic [2:0] ew;
    logic [2:0] ej;
    logic [3:0] rv;
    logic [6:0] rd;
  } vec_t;

  typedef struct {
    int         id;
    logic [6:0] cost;
  } pend_t;

  vec_t  tbl[12];
  pend_t sb[$];
  int    acc_tot[N];
  int    rv_cnt[N];
  int    grants[$];
  int    bursts[$];
  int    gaps[$];
  int    burst_acc;
  int    gap;
  int    exp_rr[5];
  int    exp_er[3];
  int    exp_fp[3];

  task automatic step();
    logic [N-1:0] pg, pr;
    pend_t        p;
    for (int i = 0; i < N; i++) begin
      req_w[3*i +: 3] = 3'(acc_tot[i]);
      req_j[3*i +: 3] = 3'(i);
    end
    pg = gnt;
    pr = req;
    @(posedge CLK);
    #1;
    if (rvalid != '0) begin
      if (sb.size() == 0) begin
        check("stray_rvalid", 32'(rvalid), 32'd0);
      end else begin
        p = sb.pop_front();
        check("rvalid_id", 32'(rvalid), 32'(1 << p.id));
        check("rdata", 32'(rdata), 32'(p.cost));
      end
      for (int i = 0; i < N; i++)
        if (rvalid[i]) rv_cnt[i]++;
    end
    for (int i = 0; i < N; i++) begin
      if (pg[i] && pr[i]) begin
        p.id   = i;
        p.cost = 7'((acc_tot[i] % 8) * 10 + i);
        sb.push_back(p);
        acc_tot[i]++;
        burst_acc++;
      end
    end
    if (pg != '0 && gnt == '0) bursts.push_back(burst_acc);
    if (pg == '0 && gnt != '0) begin
      for (int i = 0; i < N; i++)
        if (gnt[i]) grants.push_back(i);
      gaps.push_back(gap);
      gap       = 0;
      burst_acc = 0;
    end else if (gnt == '0) begin
      gap++;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req = '0;
    sb.delete();
    grants.delete();
    bursts.delete();
    gaps.delete();
    for (int i = 0; i < N; i++) begin
      acc_tot[i] = 0;
      rv_cnt[i]  = 0;
    end
    burst_acc = 0;
    gap       = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic run_grants(input int n, input int budget);
    int c;
    c = 0;
    while (grants.size() < n && c < budget) begin
      step();
      c++;
    end
    check("grant_timeout", 32'(grants.size()), 32'(n));
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 3'd0, 4'b0001, 1'b1, 3'd0, 3'd0, 4'b0000, 7'd0};
    tbl[1]  = '{4'b0001, 3'd0, 4'b0001, 1'b1, 3'd0, 3'd3, 4'b0000, 7'd0};
    tbl[2]  = '{4'b0001, 3'd1, 4'b0001, 1'b1, 3'd1, 3'd3, 4'b0001, 7'd3};
    tbl[3]  = '{4'b0001, 3'd2, 4'b0001, 1'b1, 3'd2, 3'd3, 4'b0001, 7'd13};
    tbl[4]  = '{4'b0001, 3'd3, 4'b0001, 1'b1, 3'd3, 3'd3, 4'b0001, 7'd23};
    tbl[5]  = '{4'b0001, 3'd4, 4'b0001, 1'b1, 3'd4, 3'd3, 4'b0001, 7'd33};
    tbl[6]  = '{4'b0001, 3'd5, 4'b0001, 1'b1, 3'd5, 3'd3, 4'b0001, 7'd43};
    tbl[7]  = '{4'b0001, 3'd6, 4'b0001, 1'b1, 3'd6, 3'd3, 4'b0001, 7'd53};
    tbl[8]  = '{4'b0001, 3'd7, 4'b0000, 1'b0, 3'd7, 3'd3, 4'b0001, 7'd63};
    tbl[9]  = '{4'b0001, 3'd7, 4'b0001, 1'b1, 3'd7, 3'd3, 4'b0001, 7'd73};
    tbl[10] = '{4'b0000, 3'd0, 4'b0000, 1'b0, 3'd7, 3'd3, 4'b0000, 7'd73};
    tbl[11] = '{4'b0000, 3'd0, 4'b0000, 1'b0, 3'd7, 3'd3, 4'b0000, 7'd73};

`ifdef JAM_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0, 0};
    exp_er = '{2, 0, 0};
    exp_fp = '{1, 1, 1};
`else
    exp_rr = '{0, 1, 2, 3, 0};
    exp_er = '{2, 3, 0};
    exp_fp = '{1, 3, 1};
`endif

    RST   = 1'b1;
    req   = '0;
    req_w = '0;
    req_j = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 32'({gnt, busy, W, J, rvalid, rdata}), 32'd0);
    RST = 1'b0;

    for (int r = 0; r < 12; r++) begin
      req   = tbl[r].rq;
      req_w = {9'b0, tbl[r].w};
      req_j = 12'h003;
      @(posedge CLK);
      #1;
      check($sformatf("row%0d", r),
            32'({gnt, busy, W, J, rvalid, rdata}),
            32'({tbl[r].g, tbl[r].b, tbl[r].ew, tbl[r].ej,
                 tbl[r].rv, tbl[r].rd}));
    end

    do_reset();
    req = 4'b1111;
    run_grants(5, 200);
    if (grants.size() == 5) begin
      for (int k = 0; k < 5; k++)
        check($sformatf("rr_order%0d", k), 32'(grants[k]), 32'(exp_rr[k]));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_burst%0d", k), 32'(bursts[k]), 32'd8);
        check($sformatf("rr_gap%0d", k + 1), 32'(gaps[k+1]), 32'd1);
      end
    end

    do_reset();
    req = 4'b0100;
    begin
      int c;
      c = 0;
      while (grants.size() < 3 && c < 200) begin
        if (acc_tot[2] == 3 && req[2]) req = 4'b1001;
        step();
        c++;
      end
    end
    check("er_timeout", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      for (int k = 0; k < 3; k++)
        check($sformatf("er_order%0d", k), 32'(grants[k]), 32'(exp_er[k]));
      check("er_burst0", 32'(bursts[0]), 32'd3);
      check("er_burst1", 32'(bursts[1]), 32'd8);
    end
    check("er_rvalid2", 32'(rv_cnt[2]), 32'd3);

    do_reset();
    req = 4'b0001;
    begin
      int c;
      c = 0;
      while (acc_tot[0] < 4 && c < 50) begin
        step();
        c++;
      end
    end
    check("mid_acc4", 32'(acc_tot[0]), 32'd4);
    check("mid_w", 32'(W), 32'd3);
    RST = 1'b1;
    #1;
    check("rst_async", 32'({gnt, rvalid, W, J, busy, rdata}), 32'd0);
    @(posedge CLK);
    #1;
    check("rst_no_rvalid", 32'(rvalid), 32'd0);
    do_reset();
    req = 4'b0010;
    run_grants(1, 20);
    if (grants.size() == 1)
      check("post_rst_owner", 32'(grants[0]), 32'd1);
    repeat (4) step();
    check("post_rst_acc", 32'(acc_tot[1]), 32'd4);

    do_reset();
    req = 4'b1010;
    run_grants(3, 100);
    if (grants.size() == 3)
      for (int k = 0; k < 3; k++)
        check($sformatf("fp_order%0d", k), 32'(grants[k]), 32'(exp_fp[k]));

    req = '0;
    repeat (4) step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("idle_end", 32'({gnt, busy}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
